// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles every pipeline-facing signal of the hazard controller.
//   master : the pipeline / memory side. It drives stage control bits,
//            register indices and dmem_ack. It receives forwarding selects,
//            stall/flush, dmem_req and mem_err.
//   slave  : the hazard controller, with the opposite directions.
// Clock and reset stay plain ports on the controller.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0] RsD, RtD;
    logic       BranchD, PCSrcD;
    logic [4:0] RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemToRegE, MemToRegM;
    logic       MemReadM, MemWriteM;
    logic       dmem_ack;
    logic       dmem_req;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       mem_err;

    modport master (
        output RsD, RtD, BranchD, PCSrcD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW,
               MemToRegE, MemToRegM, MemReadM, MemWriteM, dmem_ack,
        input  dmem_req, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err
    );

    modport slave (
        input  RsD, RtD, BranchD, PCSrcD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW,
               MemToRegE, MemToRegM, MemReadM, MemWriteM, dmem_ack,
        output dmem_req, ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard, stall and flush sequencer for a 5-stage MIPS pipeline (F/D/E/M/W).
// Forwarding selects and the load-use and branch hazard terms are purely
// combinational. A two-state FSM (RUN / MEM_WAIT) runs the multi-cycle
// data-memory handshake. The FSM freezes the pipe while an access is
// outstanding. If no ack arrives within MEM_TIMEOUT cycles, it forces a
// release and raises the sticky mem_err flag.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset. While low, dmem_req and every
//            stall/flush output are held at 0.
//   hz     : pipeline_hazard_ctrl_if.slave, containing:
//            stage control bits and register indices (in), dmem_ack (in),
//            dmem_req, ForwardAE/BE/AD/BD, StallF/D/E/M, FlushD/E/W and
//            mem_err (out)
//   stall_cycles, flush_count (only with HAZARD_PERF_EN defined):
//            saturating 32-bit event counters
//
// Optional feature macro: HAZARD_PERF_EN
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_ctrl_if.slave       hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 flush_count
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;

    logic             lwstall, brstall, memstall;
    logic             timeout, req_raw, req;

    // Forwarding: register 0 is never forwarded, and M takes priority over W.
    always_comb begin : forwarding
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.RsE != 5'd0 && hz.WriteRegM == hz.RsE)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.RsE != 5'd0 && hz.WriteRegW == hz.RsE)
            hz.ForwardAE = 2'b01;
        if (hz.RegWriteM && hz.RtE != 5'd0 && hz.WriteRegM == hz.RtE)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.RtE != 5'd0 && hz.WriteRegW == hz.RtE)
            hz.ForwardBE = 2'b01;
        hz.ForwardAD = hz.RegWriteM && hz.RsD != 5'd0 && hz.WriteRegM == hz.RsD;
        hz.ForwardBD = hz.RegWriteM && hz.RtD != 5'd0 && hz.WriteRegM == hz.RtD;
    end

    // A branch resolves in D, so it must wait for an ALU result still in E,
    // or for a load result still in M.
    always_comb begin : hazard_terms
        lwstall = hz.MemToRegE && hz.RtE != 5'd0 &&
                  (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
        brstall = hz.BranchD &&
                  ((hz.RegWriteE && hz.WriteRegE != 5'd0 &&
                    (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                   (hz.MemToRegM && hz.WriteRegM != 5'd0 &&
                    (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        timeout   = 1'b0;
        req_raw   = hz.MemReadM | hz.MemWriteM;
        case (state_q)
            RUN: begin
                // An ack in the same cycle as the request is a zero-wait access.
                if (req_raw && !hz.dmem_ack) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // The M stage is frozen here, so the request is held regardless of M.
                req_raw = 1'b1;
                timeout = (wcnt_q == TIMEOUT_CNT);
                if (hz.dmem_ack) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (timeout) begin
                    state_d   = RUN;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // rst_n gates the request combinationally, so an aborted access drops
    // dmem_req in the same cycle that reset asserts.
    assign req         = rst_n & req_raw;
    assign memstall    = req && !hz.dmem_ack && !timeout;
    assign hz.dmem_req = req;
    assign hz.mem_err  = mem_err_q;

    // Priority: memory stall, then data hazards, then taken-branch flush.
    // A taken branch held by brstall flushes D only once its operands are ready.
    always_comb begin : stall_flush
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (rst_n) begin
            if (memstall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else if (lwstall || brstall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (hz.PCSrcD) begin
                hz.FlushD = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin : perf_cnt
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (hz.StallF)
                stall_cycles <= sat_inc(stall_cycles);
            if (hz.FlushD || hz.FlushE)
                flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model of the memory access, kept as plain bookkeeping.
    // busy    : an access is outstanding
    // elapsed : cycles since the access started
    // err     : some access has timed out since reset
    bit   m_busy;
    int   m_elapsed;
    bit   m_err;
    int   ack_pct;

    pipeline_hazard_ctrl_if hif ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (hif.RegWriteM && hif.WriteRegM == r) return 2'b10;
        if (hif.RegWriteW && hif.WriteRegW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic reads(input logic [4:0] w);
        return w != 0 && (w == hif.RsD || w == hif.RtD);
    endfunction

    task automatic clr();
        hif.RsD = 0; hif.RtD = 0; hif.BranchD = 0; hif.PCSrcD = 0;
        hif.RsE = 0; hif.RtE = 0; hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemToRegE = 0; hif.MemToRegM = 0; hif.MemReadM = 0; hif.MemWriteM = 0;
        hif.dmem_ack = 0;
    endtask

    task automatic rnd();
        hif.RsD = 5'($urandom_range(0, 3)); hif.RtD = 5'($urandom_range(0, 3));
        hif.RsE = 5'($urandom_range(0, 3)); hif.RtE = 5'($urandom_range(0, 3));
        hif.WriteRegE = 5'($urandom_range(0, 3));
        hif.WriteRegM = 5'($urandom_range(0, 3));
        hif.WriteRegW = 5'($urandom_range(0, 3));
        hif.BranchD = 1'($urandom_range(0, 1)); hif.PCSrcD = 1'($urandom_range(0, 1));
        hif.RegWriteE = 1'($urandom_range(0, 1)); hif.RegWriteM = 1'($urandom_range(0, 1));
        hif.RegWriteW = 1'($urandom_range(0, 1));
        hif.MemToRegE = 1'($urandom_range(0, 1)); hif.MemToRegM = 1'($urandom_range(0, 1));
        hif.MemReadM = ($urandom_range(0, 3) == 0);
        hif.MemWriteM = ($urandom_range(0, 5) == 0);
        hif.dmem_ack = ($urandom_range(0, 99) < ack_pct);
    endtask

    // Checks all outputs against the model, then advances one clock.
    task automatic tick(input string tag);
        logic [1:0] eae, ebe;
        logic       ead, ebd, lw, br, req, to, ms, ack;
        logic [6:0] ev, ov;
        #1;
        eae = fwd_e(hif.RsE);
        ebe = fwd_e(hif.RtE);
        ead = hif.RegWriteM && hif.RsD != 0 && hif.WriteRegM == hif.RsD;
        ebd = hif.RegWriteM && hif.RtD != 0 && hif.WriteRegM == hif.RtD;
        lw  = hif.MemToRegE && hif.RtE != 0 && (hif.RtE == hif.RsD || hif.RtE == hif.RtD);
        br  = hif.BranchD && ((hif.RegWriteE && reads(hif.WriteRegE)) ||
                              (hif.MemToRegM && reads(hif.WriteRegM)));
        ack = hif.dmem_ack;
        req = rst_n && (m_busy || hif.MemReadM || hif.MemWriteM);
        to  = m_busy && (m_elapsed == MEM_TIMEOUT);
        ms  = req && !ack && !to;
        if (!rst_n)       ev = 7'b0000000;
        else if (ms)      ev = 7'b1111001;   // {SF,SD,SE,SM,FD,FE,FW}
        else if (lw || br) ev = 7'b1100010;
        else if (hif.PCSrcD) ev = 7'b0000100;
        else              ev = 7'b0000000;
        ov = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};
        chk({tag, "_fwdE"}, {hif.ForwardAE, hif.ForwardBE}, {eae, ebe});
        chk({tag, "_fwdD"}, {hif.ForwardAD, hif.ForwardBD}, {ead, ebd});
        chk({tag, "_stallflush"}, ov, ev);
        chk({tag, "_dmem_req"}, hif.dmem_req, req);
        chk({tag, "_mem_err"}, hif.mem_err, m_err);
        @(posedge clk);
        if (rst_n) begin
            if (!m_busy) begin
                if (req && !ack) begin m_busy = 1; m_elapsed = 1; end
            end else if (ack) begin
                m_busy = 0; m_elapsed = 0;
            end else if (to) begin
                m_busy = 0; m_elapsed = 0; m_err = 1;
            end else begin
                m_elapsed++;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_busy = 0; m_elapsed = 0; m_err = 0;
    endtask

    initial begin
        clr();
        model_reset();
        ack_pct = 30;
        // Reset state
        @(negedge clk);
        hif.MemReadM = 1;
        tick("rst");
        chk("rst_req_low", hif.dmem_req, 1'b0);
        rst_n = 1;
        clr();
        tick("idle");

        // 1: load-use
        hif.MemToRegE = 1; hif.RtE = 2; hif.RsD = 2;
        #1 chk("t1_lw", {hif.StallF, hif.StallD, hif.FlushE, hif.StallE}, 4'b1110);
        tick("t1");
        clr();
        tick("t1b");

        // 2: forwarding priority and register 0
        hif.RegWriteM = 1; hif.WriteRegM = 3; hif.RsE = 3; hif.RegWriteW = 1; hif.WriteRegW = 3;
        #1 chk("t2_m_wins", hif.ForwardAE, 2'b10);
        tick("t2a");
        hif.WriteRegM = 0;
        #1 chk("t2_w_only", hif.ForwardAE, 2'b01);
        tick("t2b");
        hif.RegWriteW = 0;
        #1 chk("t2_none", hif.ForwardAE, 2'b00);
        tick("t2c");
        hif.RsE = 0; hif.WriteRegM = 0; hif.RegWriteM = 1;
        #1 chk("t2_reg0", hif.ForwardAE, 2'b00);
        tick("t2d");
        clr();

        // 3: branch stall, then forward from M with taken-branch flush
        hif.BranchD = 1; hif.RsD = 4; hif.RegWriteE = 1; hif.WriteRegE = 4; hif.PCSrcD = 1;
        #1 chk("t3_brstall", {hif.StallF, hif.StallD, hif.FlushE, hif.FlushD}, 4'b1110);
        tick("t3a");
        hif.RegWriteE = 0; hif.WriteRegE = 0; hif.RegWriteM = 1; hif.WriteRegM = 4;
        #1 chk("t3_fwdAD", {hif.ForwardAD, hif.FlushD, hif.StallF}, 3'b110);
        tick("t3b");
        clr();

        // 4: read with ack after 3 cycles, concurrent load-use hazard
        hif.MemReadM = 1; hif.MemToRegE = 1; hif.RtE = 2; hif.RsD = 2;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_wait", {hif.dmem_req, hif.StallM, hif.FlushW, hif.FlushE}, 4'b1110);
            tick("t4w");
        end
        hif.dmem_ack = 1;
        #1 chk("t4_release", {hif.dmem_req, hif.StallM, hif.FlushW, hif.FlushE}, 4'b1001);
        tick("t4r");
        clr();
        #1 chk("t4_after", hif.dmem_req, 1'b0);
        tick("t4z");

        // 5: write that times out, then reset mid-wait
        hif.MemWriteM = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) tick("t5w");
        #1 chk("t5_release", {hif.dmem_req, hif.StallF}, 2'b10);
        tick("t5r");
        hif.MemWriteM = 0;
        #1 chk("t5_err", hif.mem_err, 1'b1);
        tick("t5e");
        hif.MemWriteM = 1;
        tick("t5s");
        tick("t5s2");
        rst_n = 0;
        model_reset();
        #1 chk("t5_rst_req", {hif.dmem_req, hif.mem_err, hif.StallF}, 3'b000);
        tick("t5rst");
        rst_n = 1;
        clr();
        tick("t5idle");

        // Randomized traffic: frequent acks, then rare acks so timeouts occur
        for (int i = 0; i < 300; i++) begin rnd(); tick("rndA"); end
        ack_pct = 3;
        for (int i = 0; i < 300; i++) begin rnd(); tick("rndB"); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
